// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC mode encodings and constants for pc_unit
package pc_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ = 3'b000,
        NPC_BEQ = 3'b001,
        NPC_BNE = 3'b010,
        NPC_J   = 3'b011,
        NPC_JAL = 3'b100,
        NPC_JR  = 3'b101,
        NPC_RET = 3'b110,
        NPC_RSV = 3'b111
    } npc_sel_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/npc_ras.sv
// rtl/npc_ras.sv - circular return-address stack; pushes when full overwrite the oldest entry
module npc_ras
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]   r_tp;
    logic [PW:0]     r_cnt;
    logic [PW-1:0]   w_top_idx;

    // r_tp is the next slot to write; the live top sits one below it
    assign w_top_idx = r_tp - PW'(1);
    assign top       = r_mem[w_top_idx];
    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == (PW+1)'(RAS_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tp  <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_tp <= r_tp + PW'(1);
            if (!full) r_cnt <= r_cnt + (PW+1)'(1);
        end else if (pop && !empty) begin
            r_tp  <= w_top_idx;
            r_cnt <= r_cnt - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_tp] <= din;
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - architectural PC register, next-PC selection, RAS control and status flags
module pc_unit
    import pc_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_wr,
    input  logic [2:0]      npc_sel,
    input  logic            zero,
    input  logic [XLEN-1:0] imm,
    input  logic [25:0]     instr_index,
    input  logic [XLEN-1:0] rs_val,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] npc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow,
    output logic            misalign
);

    localparam logic [XLEN-1:0] L_RESET_PC = XLEN'(RESET_PC);

    logic [XLEN-1:0] r_pc;
    logic            r_underflow;
    logic            r_misalign;

    npc_sel_e        w_sel;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_j_tgt;
    logic [XLEN-1:0] w_ind_raw;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_full;
    logic            w_is_ind;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_npc;

    assign w_sel      = npc_sel_e'(npc_sel);
    assign w_pc_plus4 = r_pc + XLEN'(PC_STEP);
    assign w_br_tgt   = w_pc_plus4 + (imm << 2);
    assign w_j_tgt    = {w_pc_plus4[XLEN-1:28], instr_index, 2'b00};
    // ret falls back to the register value when the stack has nothing to offer
    assign w_ind_raw  = (w_sel == NPC_RET && !w_ras_empty) ? w_ras_top : rs_val;
    assign w_is_ind   = (w_sel == NPC_JR) || (w_sel == NPC_RET);
    assign w_push     = pc_wr && (w_sel == NPC_JAL);
    assign w_pop      = pc_wr && (w_sel == NPC_RET);

    always_comb begin
        w_npc = w_pc_plus4;
        case (w_sel)
            NPC_BEQ:         w_npc = zero  ? w_br_tgt : w_pc_plus4;
            NPC_BNE:         w_npc = !zero ? w_br_tgt : w_pc_plus4;
            NPC_J, NPC_JAL:  w_npc = w_j_tgt;
            NPC_JR, NPC_RET: w_npc = {w_ind_raw[XLEN-1:2], 2'b00};
            default:         w_npc = w_pc_plus4;
        endcase
    end

    npc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_plus4),
        .top   (w_ras_top),
        .empty (w_ras_empty),
        .full  (w_ras_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= L_RESET_PC;
            r_underflow <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_underflow <= w_pop && w_ras_empty;
            if (pc_wr) begin
                r_pc <= w_npc;
                if (w_is_ind && (w_ind_raw[1:0] != 2'b00)) r_misalign <= 1'b1;
            end
        end
    end

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign npc           = w_npc;
    assign ras_empty     = w_ras_empty;
    assign ras_full      = w_ras_full;
    assign ras_underflow = r_underflow;
    assign misalign      = r_misalign;

endmodule
